// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the VRAM burst fetcher: the controller state
// encoding and the VRAM word-address / data / burst-count widths.
// -----------------------------------------------------------------------------
package vram_pkg;

  localparam int VRAM_AW = 15;  // 32-bit word address width of the VRAM port
  localparam int VRAM_DW = 32;  // VRAM read data width
  localparam int CNT_W   = 16;  // burst length width (0..32768 words)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

endpackage

// File: rtl/vram_fetch_fifo.sv
// -----------------------------------------------------------------------------
// vram_fetch_fifo
// Read-data FIFO for the VRAM fetcher. DEPTH must be a power of two so the
// pointers wrap naturally. Flush has priority over push and pop; pop on an
// empty FIFO and push on a full FIFO are ignored.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_flush      empty the FIFO (pointers and count to zero)
//   i_push       write i_wdata at the tail
//   i_wdata      write data
//   i_pop        drop the head entry
//   o_rdata      head entry (combinational)
//   o_valid      FIFO not empty
//   o_count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module vram_fetch_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [VRAM_DW-1:0]     i_wdata,
  input  logic                   i_pop,
  output logic [VRAM_DW-1:0]     o_rdata,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [VRAM_DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !w_full  && !i_flush;
  assign w_pop   = i_pop  && !w_empty && !i_flush;

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked
  // by the count, so resetting it would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/vram_fetch.sv
// -----------------------------------------------------------------------------
// vram_fetch
// Burst reader for a 32-bit VRAM read port. A start request latches a word
// address and a word count, then one read at a time is issued on
// vram_strobe/vram_addr and each acknowledged word is pushed into a FIFO that
// a consumer drains through rd_data/rd_valid/rd_pop. Requests are throttled
// so the FIFO never overflows. An abort cancels the burst and flushes the FIFO.
//
// Optional build macro: VRAM_FETCH_STATS_EN adds the stall_cnt output.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle burst request (honoured only in IDLE)
//   start_addr         first word address of the burst
//   word_cnt           burst length in words; 0 completes immediately
//   abort              one-cycle cancel request (honoured only in FETCH)
//   busy               controller not IDLE
//   done               one-cycle pulse once the last word is in the FIFO
//   vram_addr          word address to VRAM (held while vram_strobe is high)
//   vram_strobe        read request to VRAM, held until vram_ack
//   vram_rddata        VRAM read data, valid with vram_ack
//   vram_ack           one-cycle VRAM acknowledge
//   rd_data            FIFO head word
//   rd_valid           FIFO not empty
//   rd_pop             consumer pop
//   stall_cnt          (VRAM_FETCH_STATS_EN) cycles strobe waited for ack
// -----------------------------------------------------------------------------
module vram_fetch
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VRAM_AW-1:0] start_addr,
  input  logic [CNT_W-1:0]   word_cnt,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_strobe,
  input  logic [VRAM_DW-1:0] vram_rddata,
  input  logic               vram_ack,
  output logic [VRAM_DW-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_pop
`ifdef VRAM_FETCH_STATS_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             r_state;
  logic [VRAM_AW-1:0] r_addr;
  logic               r_strobe;
  logic               r_done;
  logic [CNT_W-1:0]   r_remaining;

  logic [CW-1:0]      w_count;
  logic               w_room;
  logic               w_ack_ok;
  logic               w_push;
  logic               w_flush;
  logic               w_start_burst;

  // The strobe is held until acked, so a high strobe is exactly "one request
  // outstanding"; acks without it (or outside FETCH) are dropped here.
  assign w_ack_ok      = (r_state == ST_FETCH) && r_strobe && vram_ack;
  // Abort wins over a coincident ack, including the final one.
  assign w_push        = w_ack_ok && !abort;
  assign w_start_burst = (r_state == ST_IDLE) && start && (word_cnt != '0);
  assign w_flush       = w_start_burst || ((r_state == ST_FETCH) && abort);
  // Requests only rise in non-ack cycles, so nothing is pushed in the cycle
  // this is evaluated and the registered count is the full occupancy.
  assign w_room        = (w_count < CW'(FIFO_DEPTH));

  vram_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (vram_rddata),
    .i_pop   (rd_pop),
    .o_rdata (rd_data),
    .o_valid (rd_valid),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_strobe <= 1'b0;
          if (start) begin
            if (word_cnt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= start_addr;
              r_remaining <= word_cnt;
              // FIFO is flushed on this edge, so there is room for word one.
              r_strobe    <= 1'b1;
              r_state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (abort) begin
            r_strobe    <= 1'b0;
            r_remaining <= '0;
            r_state     <= ST_ABORT;
          end else if (w_ack_ok) begin
            // Address only moves on an ack, when strobe drops: it is
            // therefore stable for the whole time strobe is high.
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_strobe    <= 1'b0;
            if (r_remaining == CNT_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_strobe <= w_room && (r_remaining != '0);
          end
        end
        ST_ABORT: begin
          r_strobe <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_strobe <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign vram_addr   = r_addr;
  assign vram_strobe = r_strobe;

`ifdef VRAM_FETCH_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (r_strobe && !vram_ack && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_fetch.sv
// -----------------------------------------------------------------------------
// tb_vram_fetch
// Directed bench for vram_fetch (FIFO_DEPTH = 4). A background process on the
// falling clock edge models the VRAM port (automatic acks after a set number
// of strobe cycles, or manually requested acks), the consumer, and simple
// monitors (done pulses, strobe cycles, address stability while strobed).
// -----------------------------------------------------------------------------
module tb_vram_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] word_cnt;
  logic        abort;
  logic        busy;
  logic        done;
  logic [14:0] vram_addr;
  logic        vram_strobe;
  logic [31:0] vram_rddata;
  logic        vram_ack;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_pop;

  vram_fetch #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .word_cnt    (word_cnt),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .vram_addr   (vram_addr),
    .vram_strobe (vram_strobe),
    .vram_rddata (vram_rddata),
    .vram_ack    (vram_ack),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_pop      (rd_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controls written only by the main initial block.
  bit resp_en;
  int lat;
  bit pop_en;
  int pops_wanted;
  int acks_wanted;

  // State written only by the background process.
  int          pops_done;
  int          acks_given;
  int          wait_cnt;
  int          done_cnt;
  int          strobe_cycles;
  int          hold_err;
  logic        prev_strobe;
  logic [14:0] prev_addr;
  logic [14:0] ack_log [$];
  logic [31:0] pop_log [$];

  int cmp_cnt;
  int err_cnt;

  function automatic logic [31:0] exp_data(input logic [14:0] a);
    return {a, 2'b10, ~a};
  endfunction

  initial begin
    pops_done     = 0;
    acks_given    = 0;
    wait_cnt      = 0;
    done_cnt      = 0;
    strobe_cycles = 0;
    hold_err      = 0;
    prev_strobe   = 1'b0;
    prev_addr     = '0;
    vram_ack      = 1'b0;
    vram_rddata   = '0;
    rd_pop        = 1'b0;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (vram_strobe) strobe_cycles++;
    if (prev_strobe && vram_strobe && (vram_addr != prev_addr)) hold_err++;
    prev_strobe = vram_strobe;
    prev_addr   = vram_addr;

    if (rd_valid && (pop_en || (pops_done < pops_wanted))) begin
      rd_pop = 1'b1;
      pop_log.push_back(rd_data);
      if (!pop_en) pops_done++;
    end else begin
      rd_pop = 1'b0;
    end

    if (resp_en) begin
      if (vram_strobe && !vram_ack) begin
        if (wait_cnt + 1 >= lat) begin
          vram_ack    = 1'b1;
          vram_rddata = exp_data(vram_addr);
          ack_log.push_back(vram_addr);
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        vram_ack = 1'b0;
        wait_cnt = 0;
      end
    end else if (acks_given < acks_wanted) begin
      vram_ack    = 1'b1;
      vram_rddata = exp_data(vram_addr);
      acks_given++;
    end else begin
      vram_ack = 1'b0;
    end
  end

  task automatic pulse_start(input logic [14:0] a, input logic [15:0] n);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    word_cnt   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    cmp_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int i;
    i = 0;
    while (!vram_strobe && i < budget) begin
      @(negedge clk);
      i++;
    end
    cmp_cnt++;
    if (vram_strobe !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_strobe_timeout: strobe=%b, required 1", name, vram_strobe);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    cmp_cnt++; if (busy !== 1'b0)       begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    cmp_cnt++; if (done !== 1'b0)       begin err_cnt++; $display("FAIL rst_done: got %b want 0", done); end
    cmp_cnt++; if (vram_strobe !== 1'b0) begin err_cnt++; $display("FAIL rst_strobe: got %b want 0", vram_strobe); end
    cmp_cnt++; if (vram_addr !== 15'h0) begin err_cnt++; $display("FAIL rst_addr: got %h want 0000", vram_addr); end
    cmp_cnt++; if (rd_valid !== 1'b0)   begin err_cnt++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_burst();
    int ab, pb, d0;
    logic [14:0] ea;
    resp_en = 1'b1; lat = 4; pop_en = 1'b1;
    ab = ack_log.size(); pb = pop_log.size(); d0 = done_cnt;
    pulse_start(15'h0100, 16'd8);
    wait_idle("burst", 200);
    repeat (3) @(negedge clk);
    #1;
    cmp_cnt++; if (ack_log.size() - ab !== 8) begin err_cnt++; $display("FAIL burst_acks: got %0d want 8", ack_log.size() - ab); end
    for (int i = 0; i < 8; i++) begin
      ea = 15'h0100 + 15'(i);
      cmp_cnt++;
      if (ack_log[ab + i] !== ea) begin err_cnt++; $display("FAIL burst_addr%0d: got %h want %h", i, ack_log[ab + i], ea); end
      cmp_cnt++;
      if (pop_log[pb + i] !== exp_data(ea)) begin err_cnt++; $display("FAIL burst_data%0d: got %h want %h", i, pop_log[pb + i], exp_data(ea)); end
    end
    cmp_cnt++; if (pop_log.size() - pb !== 8) begin err_cnt++; $display("FAIL burst_pops: got %0d want 8", pop_log.size() - pb); end
    cmp_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL burst_done: got %0d pulses want 1", done_cnt - d0); end
    cmp_cnt++; if (hold_err !== 0) begin err_cnt++; $display("FAIL burst_addr_hold: got %0d changes want 0", hold_err); end
    cmp_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL burst_drained: rd_valid %b want 0", rd_valid); end
  endtask

  task automatic test_wrap();
    int ab, d0;
    logic [14:0] wexp [4];
    wexp = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    resp_en = 1'b1; lat = 1; pop_en = 1'b1;
    ab = ack_log.size(); d0 = done_cnt;
    pulse_start(15'h7FFE, 16'd4);
    wait_idle("wrap", 100);
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (ack_log[ab + i] !== wexp[i]) begin err_cnt++; $display("FAIL wrap_addr%0d: got %h want %h", i, ack_log[ab + i], wexp[i]); end
    end
    cmp_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL wrap_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int ab, pb, d0, i;
    logic [14:0] ea;
    resp_en = 1'b1; lat = 2; pop_en = 1'b0;
    ab = ack_log.size(); pb = pop_log.size(); d0 = done_cnt;
    pulse_start(15'h0200, 16'd10);
    i = 0;
    while (ack_log.size() - ab < 4 && i < 100) begin
      @(negedge clk);
      i++;
    end
    repeat (10) @(negedge clk);
    #1;
    cmp_cnt++; if (ack_log.size() - ab !== 4) begin err_cnt++; $display("FAIL bp_full_acks: got %0d want 4", ack_log.size() - ab); end
    cmp_cnt++; if (vram_strobe !== 1'b0) begin err_cnt++; $display("FAIL bp_full_strobe: got %b want 0", vram_strobe); end
    cmp_cnt++; if (rd_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_full_valid: got %b want 1", rd_valid); end
    pops_wanted = pops_wanted + 1;
    repeat (12) @(negedge clk);
    #1;
    cmp_cnt++; if (ack_log.size() - ab !== 5) begin err_cnt++; $display("FAIL bp_one_pop_acks: got %0d want 5", ack_log.size() - ab); end
    cmp_cnt++; if (vram_strobe !== 1'b0) begin err_cnt++; $display("FAIL bp_one_pop_strobe: got %b want 0", vram_strobe); end
    cmp_cnt++; if (pop_log[pb] !== exp_data(15'h0200)) begin err_cnt++; $display("FAIL bp_first_word: got %h want %h", pop_log[pb], exp_data(15'h0200)); end
    pop_en = 1'b1;
    wait_idle("bp", 300);
    repeat (3) @(negedge clk);
    #1;
    cmp_cnt++; if (ack_log.size() - ab !== 10) begin err_cnt++; $display("FAIL bp_total_acks: got %0d want 10", ack_log.size() - ab); end
    cmp_cnt++; if (pop_log.size() - pb !== 10) begin err_cnt++; $display("FAIL bp_total_pops: got %0d want 10", pop_log.size() - pb); end
    for (int k = 0; k < 10; k++) begin
      ea = 15'h0200 + 15'(k);
      cmp_cnt++;
      if (pop_log[pb + k] !== exp_data(ea)) begin err_cnt++; $display("FAIL bp_data%0d: got %h want %h", k, pop_log[pb + k], exp_data(ea)); end
    end
    cmp_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_zero_count();
    int s0, d0;
    s0 = strobe_cycles; d0 = done_cnt;
    pulse_start(15'h0123, 16'd0);
    cmp_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL zero_done_pulse: got %b want 1", done); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL zero_busy: got %b want 0", busy); end
    @(negedge clk);
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL zero_done_end: got %b want 0", done); end
    repeat (3) @(negedge clk);
    #1;
    cmp_cnt++; if (strobe_cycles !== s0) begin err_cnt++; $display("FAIL zero_strobe: got %0d strobe cycles want 0", strobe_cycles - s0); end
    cmp_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0;
    resp_en = 1'b0; pop_en = 1'b0;
    d0 = done_cnt;
    pulse_start(15'h0300, 16'd8);
    wait_strobe("abort_first", 10);
    // Accepted ack followed by a stray ack in the strobe-low cycle.
    #1;
    acks_wanted = acks_wanted + 2;
    repeat (2) @(negedge clk);
    wait_strobe("abort_second", 10);
    cmp_cnt++; if (vram_addr !== 15'h0301) begin err_cnt++; $display("FAIL stray_ack_addr: got %h want 0301", vram_addr); end
    cmp_cnt++; if (rd_valid !== 1'b1) begin err_cnt++; $display("FAIL abort_pre_valid: got %b want 1", rd_valid); end
    @(negedge clk);
    abort = 1'b1;
    #1;
    acks_wanted = acks_wanted + 1;
    @(negedge clk);
    abort = 1'b0;
    cmp_cnt++; if (vram_strobe !== 1'b0) begin err_cnt++; $display("FAIL abort_strobe: got %b want 0", vram_strobe); end
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL abort_state_busy: got %b want 1", busy); end
    cmp_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_flush: got %b want 0", rd_valid); end
    @(negedge clk);
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_idle: got %b want 0", busy); end
    cmp_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_stale_ack: rd_valid %b want 0", rd_valid); end
    repeat (2) @(negedge clk);
    #1;
    cmp_cnt++; if (done_cnt !== d0) begin err_cnt++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_abort_final_ack();
    int d0;
    resp_en = 1'b0; pop_en = 1'b0;
    d0 = done_cnt;
    pulse_start(15'h0400, 16'd1);
    wait_strobe("abort_final", 10);
    #1;
    acks_wanted = acks_wanted + 1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL abort_wins_done: got %b want 0", done); end
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL abort_wins_state: busy %b want 1", busy); end
    cmp_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_wins_push: rd_valid %b want 0", rd_valid); end
    repeat (3) @(negedge clk);
    #1;
    cmp_cnt++; if (done_cnt !== d0) begin err_cnt++; $display("FAIL abort_wins_no_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_burst();
    int ab, d0, i;
    resp_en = 1'b1; lat = 3; pop_en = 1'b0;
    ab = ack_log.size();
    pulse_start(15'h0500, 16'd6);
    i = 0;
    while (ack_log.size() - ab < 2 && i < 100) begin
      @(negedge clk);
      i++;
    end
    wait_strobe("rst_mid", 10);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_cnt++; if (busy !== 1'b0)        begin err_cnt++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    cmp_cnt++; if (vram_strobe !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_strobe: got %b want 0", vram_strobe); end
    cmp_cnt++; if (vram_addr !== 15'h0) begin err_cnt++; $display("FAIL rst_mid_addr: got %h want 0000", vram_addr); end
    cmp_cnt++; if (rd_valid !== 1'b0)    begin err_cnt++; $display("FAIL rst_mid_valid: got %b want 0", rd_valid); end
    cmp_cnt++; if (done !== 1'b0)        begin err_cnt++; $display("FAIL rst_mid_done: got %b want 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pop_en = 1'b1;
    ab = ack_log.size(); d0 = done_cnt;
    pulse_start(15'h0600, 16'd2);
    wait_idle("rst_restart", 100);
    repeat (3) @(negedge clk);
    #1;
    cmp_cnt++; if (ack_log.size() - ab !== 2) begin err_cnt++; $display("FAIL restart_acks: got %0d want 2", ack_log.size() - ab); end
    cmp_cnt++; if (ack_log[ab] !== 15'h0600) begin err_cnt++; $display("FAIL restart_addr0: got %h want 0600", ack_log[ab]); end
    cmp_cnt++; if (ack_log[ab + 1] !== 15'h0601) begin err_cnt++; $display("FAIL restart_addr1: got %h want 0601", ack_log[ab + 1]); end
    cmp_cnt++; if (done_cnt - d0 !== 1) begin err_cnt++; $display("FAIL restart_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  initial begin
    cmp_cnt     = 0;
    err_cnt     = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_addr  = '0;
    word_cnt    = '0;
    abort       = 1'b0;
    resp_en     = 1'b1;
    lat         = 1;
    pop_en      = 1'b0;
    pops_wanted = 0;
    acks_wanted = 0;

    test_reset();
    test_burst();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_abort_final_ack();
    test_reset_mid_burst();

    cmp_cnt++;
    if (hold_err !== 0) begin
      err_cnt++;
      $display("FAIL addr_hold_overall: got %0d changes while strobed, want 0", hold_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_fetch.md
VRAM_FETCH -- requirements
Module: vram_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning read-data FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  system clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a burst.
REQ-005 start_addr  input  15  first 32-bit word address of the burst.
REQ-006 word_cnt  input  16  words in the burst, 0..32768.
REQ-007 abort  input  1  one-cycle request to cancel the current burst.
REQ-008 busy  output  1  high while not IDLE.
REQ-009 done  output  1  one-cycle pulse when the last word has been pushed into the FIFO.
REQ-010 vram_addr  output  15  word address to the VRAM read port.
REQ-011 vram_strobe  output  1  read request to the VRAM read port.
REQ-012 vram_rddata  input  32  read data, valid only when vram_ack is high.
REQ-013 vram_ack  input  1  one-cycle acknowledge from the VRAM read port.
REQ-014 rd_data  output  32  FIFO head word.
REQ-015 rd_valid  output  1  FIFO not empty.
REQ-016 rd_pop  input  1  consumer pop; ignored when rd_valid is low.

Function
REQ-017 States SHALL be IDLE, FETCH and ABORT.
REQ-018 IDLE + start: latch start_addr and word_cnt, clear the FIFO, go to FETCH; word_cnt=0 SHALL instead pulse done next cycle and stay IDLE.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 vram_strobe and vram_addr SHALL be registered; vram_addr SHALL be held stable while vram_strobe is high.
REQ-021 vram_strobe SHALL be high in FETCH when words remain un-acked, no ack occurs this cycle, and FIFO occupancy (including the word being pushed this cycle) < FIFO_DEPTH.
REQ-022 At most one request SHALL be outstanding; strobe SHALL stay high until ack, with the arbiter slot latency absorbed (up to 4 cycles).
REQ-023 On vram_ack in FETCH: push vram_rddata, increment vram_addr modulo 2^15 (0x7FFF wraps to 0x0000), decrement remaining count, drop strobe for that cycle.
REQ-024 On the ack of the final word: pulse done and go to IDLE in the same cycle.
REQ-025 vram_ack when no request is outstanding, or in IDLE/ABORT, SHALL be discarded.
REQ-026 abort in FETCH: strobe low next cycle, flush the FIFO, enter ABORT for exactly one cycle, then IDLE; no done pulse.
REQ-027 abort and the final ack in the same cycle: abort wins.
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged; pop on empty SHALL be a no-op.
REQ-029 rd_data SHALL be combinational from the FIFO head.

Reset
REQ-030 rst_n low SHALL force IDLE, vram_strobe=0, vram_addr=0, busy=0, done=0, FIFO empty, rd_valid=0, remaining count=0, and the stall counter (if present) to 0.
REQ-031 Reset deassertion mid-burst SHALL resume in IDLE; stale acks SHALL be discarded.

Configuration
REQ-032 When VRAM_FETCH_STATS_EN is defined, add output stall_cnt (16 bits): increments each cycle vram_strobe is high and vram_ack is low, saturates at 0xFFFF, clears on accepted start.
REQ-033 When VRAM_FETCH_STATS_EN is undefined, the port and the counter SHALL NOT exist.

Structure
REQ-034 The state encoding and the VRAM word-address width constant (15) SHALL be in shared package vram_pkg.
REQ-035 The FIFO SHALL be one sub-module, vram_fetch_fifo (parameter DEPTH, width 32).

Verification
REQ-036 start_addr=0x0100, word_cnt=8, slot every 4 cycles, consumer always popping -> addresses 0x0100..0x0107 in order, 8 pushes, one done pulse.
REQ-037 start_addr=0x7FFE, word_cnt=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-038 FIFO_DEPTH=4, word_cnt=10, no pops -> strobe low after 4 pushes; one pop -> exactly one more request.
REQ-039 word_cnt=0 -> done one cycle later, vram_strobe never high.
REQ-040 abort while a request is outstanding, ack next cycle -> ack discarded, FIFO empty, IDLE after one ABORT cycle, no done pulse.
REQ-041 rst_n low mid-burst -> all outputs reach reset values immediately; a start issued after release runs normally.
